// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared types and constants for the instruction fetch unit.
//   state_t    : fetch controller state encoding
//   INSTR_STEP : byte distance between consecutive instructions
//   NOP        : canonical no-op encoding, available to decode-side logic
package fetch_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam int INSTR_STEP = 4;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
// Synchronous in-order FIFO that buffers {instruction, pc} pairs.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous reset, active low
//   push   : write wdata (ignored when full unless popping in the same cycle)
//   pop    : drop the head entry (ignored when empty)
//   clear  : empty the FIFO; wins over push/pop
//   wdata  : entry to write
//   rdata  : head entry (meaningful only when !empty)
//   count  : number of valid entries
//   full   : count == DEPTH
//   empty  : count == 0
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO may accept a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && !clear && do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
// Instruction fetch unit: owns the PC, issues pipelined reads to instruction
// memory and buffers returned instructions in order for decode.
// Optional feature macro: FETCH_BYPASS_EN (zero-latency bypass of an empty
// queue straight from RDATA to INSTR_OUT).
// Ports:
//   clk, rst          : clock / synchronous active-low reset
//   mem_rdy           : memory accepts the current request
//   valid, RDATA      : in-order read response from memory
//   proc_req, ADDR_OUT: read request and its address; we is tied low
//   redirect,
//   redirect_addr     : one-cycle restart of fetch at a new PC
//   instr_ready       : decode accepts the head instruction
//   instr_valid,
//   INSTR_OUT,
//   instr_pc          : head instruction and its address
//
// state | meaning
// INIT  | first cycle out of reset, no requests
// FETCH | issuing requests while credit allows
// STALL | credit exhausted, proc_req low
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              BITS       = 32,
  parameter int              DEPTH      = 4,
  parameter int              MAX_OUT    = 2,
  parameter logic [BITS-1:0] RESET_ADDR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_rdy,
  input  logic            valid,
  input  logic [BITS-1:0] RDATA,
  output logic            proc_req,
  output logic            we,
  output logic [BITS-1:0] ADDR_OUT,
  input  logic            redirect,
  input  logic [BITS-1:0] redirect_addr,
  input  logic            instr_ready,
  output logic            instr_valid,
  output logic [BITS-1:0] INSTR_OUT,
  output logic [BITS-1:0] instr_pc
);

  localparam int              CW      = $clog2(DEPTH+1);
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [CW-1:0]   MAX_C   = CW'(MAX_OUT);
  localparam logic [BITS-1:0] STEP    = BITS'(INSTR_STEP);

  state_t          state;
  state_t          state_nx;
  logic [BITS-1:0] pc;
  logic [BITS-1:0] resp_pc;     // address belonging to the next kept response
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   out_nx;
  logic [CW-1:0]   cnt_nx;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic [2*BITS-1:0] fifo_rdata;
  logic            accept;
  logic            resp;
  logic            keep;
  logic            bypass;
  logic            push;
  logic            pop;
  logic            credit;
  logic            credit_nx;

  assign we       = 1'b0;
  assign ADDR_OUT = pc;
  assign accept   = proc_req && mem_rdy;
  // Responses with nothing outstanding are not ours to track.
  assign resp     = valid && (outstanding != '0);
  assign keep     = resp && (drop_cnt == '0) && !redirect;

`ifdef FETCH_BYPASS_EN
  assign bypass = keep && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  assign pop  = !fifo_empty && instr_ready;
  assign push = keep && !(bypass && instr_ready);

  assign instr_valid = !fifo_empty || bypass;
  assign INSTR_OUT   = !fifo_empty ? fifo_rdata[2*BITS-1:BITS] : (bypass ? RDATA   : '0);
  assign instr_pc    = !fifo_empty ? fifo_rdata[BITS-1:0]      : (bypass ? resp_pc : '0);

  // In-flight requests count against queue space so every response has a slot.
  assign credit   = (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_C) && (outstanding < MAX_C);
  assign proc_req = (state == FETCH) && credit;

  always_comb begin
    out_nx = outstanding;
    case ({accept, resp})
      2'b10:   out_nx = outstanding + 1'b1;
      2'b01:   out_nx = outstanding - 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cnt_nx = fifo_count;
    if (redirect)         cnt_nx = '0;
    else if (push && !pop) cnt_nx = fifo_count + 1'b1;
    else if (!push && pop) cnt_nx = fifo_count - 1'b1;
  end

  // Judging credit on next-cycle counts lets FETCH resume right after a pop.
  assign credit_nx = (({1'b0, out_nx} + {1'b0, cnt_nx}) < DEPTH_C) && (out_nx < MAX_C);

  always_comb begin
    state_nx = state;
    case (state)
      INIT:         state_nx = FETCH;
      FETCH, STALL: state_nx = credit_nx ? FETCH : STALL;
      default:      state_nx = INIT;
    endcase
    if (redirect) state_nx = FETCH;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= INIT;
      pc          <= RESET_ADDR;
      resp_pc     <= RESET_ADDR;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_nx;
      outstanding <= out_nx;
      if (redirect) begin
        pc       <= redirect_addr;
        resp_pc  <= redirect_addr;
        // Everything still in flight after this edge is stale, including a
        // request accepted in this same cycle.
        drop_cnt <= out_nx;
      end else begin
        if (accept) pc <= pc + STEP;
        if (resp && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
        if (keep) resp_pc <= resp_pc + STEP;
      end
    end
  end

  fetch_fifo #(
    .W     (2*BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .wdata ({RDATA, resp_pc}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  resp_orphan: assert property (@(posedge clk) disable iff (!rst)
    !(valid && (outstanding == '0)));

  queue_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int BITS = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            mem_rdy;
  logic            valid;
  logic [BITS-1:0] RDATA;
  logic            proc_req;
  logic            we;
  logic [BITS-1:0] ADDR_OUT;
  logic            redirect;
  logic [BITS-1:0] redirect_addr;
  logic            instr_ready;
  logic            instr_valid;
  logic [BITS-1:0] INSTR_OUT;
  logic [BITS-1:0] instr_pc;

  int checks  = 0;
  int errors  = 0;
  int acc_cnt = 0;
  bit resp_en;
  logic [BITS-1:0] pend[$];

  always #5 clk = ~clk;

  fetch_queue #(
    .BITS       (BITS),
    .DEPTH      (4),
    .MAX_OUT    (2),
    .RESET_ADDR ('0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_rdy       (mem_rdy),
    .valid         (valid),
    .RDATA         (RDATA),
    .proc_req      (proc_req),
    .we            (we),
    .ADDR_OUT      (ADDR_OUT),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .instr_ready   (instr_ready),
    .instr_valid   (instr_valid),
    .INSTR_OUT     (INSTR_OUT),
    .instr_pc      (instr_pc)
  );

  function automatic logic [BITS-1:0] mem_word(input logic [BITS-1:0] a);
    return 32'hC000_0000 | a;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ends the current cycle: records an accept, advances to the next negedge,
  // then drives the memory response for the new cycle (one cycle after accept).
  task automatic tick();
    logic r;
    r = rst;
    if (proc_req && mem_rdy && r) begin
      pend.push_back(ADDR_OUT);
      acc_cnt++;
    end
    @(negedge clk);
    if (!r) pend.delete();
    redirect = 1'b0;
    if (resp_en && pend.size() > 0) begin
      valid = 1'b1;
      RDATA = mem_word(pend.pop_front());
    end else begin
      valid = 1'b0;
      RDATA = '0;
    end
    #1;
  endtask

  // Leaves the bench in the first FETCH cycle with ADDR_OUT = 0.
  task automatic do_reset();
    rst = 1'b0; redirect = 1'b0; instr_ready = 1'b0; mem_rdy = 1'b1; resp_en = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    acc_cnt = 0;
  endtask

  initial begin
    rst = 1'b0; mem_rdy = 1'b1; valid = 1'b0; RDATA = '0; redirect = 1'b0;
    redirect_addr = '0; instr_ready = 1'b0; resp_en = 1'b1;
    tick();
    tick();
    chk("rst_proc_req", proc_req, 0);
    chk("rst_we", we, 0);
    chk("rst_addr", ADDR_OUT, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", INSTR_OUT, 0);
    chk("rst_instr_pc", instr_pc, 0);
    rst = 1'b1;
    chk("init_no_req", proc_req, 0);
    tick();

    // streaming, one response per accept, decode always ready
    instr_ready = 1'b1;
    chk("t1_req", proc_req, 1);
    chk("t1_addr0", ADDR_OUT, 0);
    tick();
    chk("t1_latency", instr_valid, 0);
    chk("t1_addr1", ADDR_OUT, 4);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t1_valid", instr_valid, 1);
      chk("t1_pc", instr_pc, 4*k);
      chk("t1_instr", INSTR_OUT, 32'hC000_0000 + 4*k);
      chk("t1_addr", ADDR_OUT, 4*k + 8);
      tick();
    end

    // decode stalled: credit caps requests at queue depth
    do_reset();
    repeat (10) tick();
    chk("t2_accepts", acc_cnt, 4);
    chk("t2_stall", proc_req, 0);
    chk("t2_head", instr_pc, 0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("t2_resume", proc_req, 1);
    chk("t2_resume_addr", ADDR_OUT, 16);
    chk("t2_head_pop", instr_pc, 4);

    // memory not ready: request held stable
    do_reset();
    instr_ready = 1'b1;
    mem_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t3_req_held", proc_req, 1);
      chk("t3_addr_held", ADDR_OUT, 0);
      tick();
    end
    mem_rdy = 1'b1;
    tick();
    chk("t3_next_addr", ADDR_OUT, 4);

    // redirect with two requests in flight
    do_reset();
    resp_en = 1'b0;
    tick();
    tick();
    chk("t4_out_cap", proc_req, 0);
    redirect = 1'b1;
    redirect_addr = 32'h100;
    tick();
    chk("t4_redir_addr", ADDR_OUT, 32'h100);
    chk("t4_no_credit", proc_req, 0);
    chk("t4_flush", instr_valid, 0);
    resp_en = 1'b1;
    tick();
    chk("t4_drop0", instr_valid, 0);
    tick();
    chk("t4_req", proc_req, 1);
    chk("t4_req_addr", ADDR_OUT, 32'h100);
    chk("t4_drop1", instr_valid, 0);
    tick();
    chk("t4_lat", instr_valid, 0);
    tick();
    chk("t4_valid", instr_valid, 1);
    chk("t4_pc", instr_pc, 32'h100);
    chk("t4_instr", INSTR_OUT, 32'hC000_0100);

    // redirect coinciding with a response and an accept
    do_reset();
    tick();
    chk("t5_req", proc_req, 1);
    chk("t5_addr", ADDR_OUT, 4);
    redirect = 1'b1;
    redirect_addr = 32'h200;
    tick();
    chk("t5_flush", instr_valid, 0);
    chk("t5_redir_addr", ADDR_OUT, 32'h200);
    chk("t5_req_redir", proc_req, 1);
    tick();
    chk("t5_stale", instr_valid, 0);
    tick();
    chk("t5_valid", instr_valid, 1);
    chk("t5_pc", instr_pc, 32'h200);
    chk("t5_instr", INSTR_OUT, 32'hC000_0200);

    // reset in the middle of a stream
    do_reset();
    instr_ready = 1'b1;
    repeat (4) tick();
    chk("t6_pre_valid", instr_valid, 1);
    rst = 1'b0;
    tick();
    chk("t6_proc_req", proc_req, 0);
    chk("t6_addr", ADDR_OUT, 0);
    chk("t6_instr_valid", instr_valid, 0);
    chk("t6_instr", INSTR_OUT, 0);
    chk("t6_instr_pc", instr_pc, 0);
    rst = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
